// File: rtl/cache_tag_array.sv
// N-way set-associative tag store (tag/valid/dirty per way, round-robin victim per set) with self-sequenced clear.
// Latency: reads return one cycle after rd_en. Backpressure: none; while init_busy is high, reads and writes are dropped.
// The clear sweep takes SETS cycles and runs after reset or after a flush_req that arrives while idle.
module cache_tag_array #(
    parameter int NUM_WAYS      = 2,
    parameter int INDEX_WIDTH   = 7,
    parameter int TAG_WIDTH     = 21,
    parameter int ENABLE_BYPASS = 1
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                flush_req,
    output logic                                                init_busy,
    input  logic                                                rd_en,
    input  logic [INDEX_WIDTH-1:0]                              rd_index,
    output logic [NUM_WAYS*TAG_WIDTH-1:0]                       rd_tag,
    output logic [NUM_WAYS-1:0]                                 rd_valid,
    output logic [NUM_WAYS-1:0]                                 rd_dirty,
    output logic [((NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1)-1:0]  rd_victim,
    input  logic [NUM_WAYS-1:0]                                 wr_en,
    input  logic [INDEX_WIDTH-1:0]                              wr_index,
    input  logic [TAG_WIDTH-1:0]                                wr_tag,
    input  logic                                                wr_valid,
    input  logic                                                wr_dirty,
    input  logic                                                victim_adv
);

    localparam int SETS  = 1 << INDEX_WIDTH;
    localparam int PTR_W = INDEX_WIDTH + 1;
    localparam int VW    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [PTR_W-1:0]     clear_ptr, clear_ptr_nxt;
    logic [INDEX_WIDTH-1:0] clear_idx;

    logic [TAG_WIDTH-1:0] tag_mem    [SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]  valid_mem  [SETS];
    logic [NUM_WAYS-1:0]  dirty_mem  [SETS];
    logic [VW-1:0]        victim_mem [SETS];

    logic                 wr_act;
    logic                 rd_hit;
    logic [VW-1:0]        victim_wr_cur;
    logic [VW-1:0]        victim_wr_nxt;

    assign clear_idx = clear_ptr[INDEX_WIDTH-1:0];
    assign init_busy = (state == CLEAR);

    // A flush in the same cycle squashes any write or victim update.
    assign wr_act = (state == IDLE) && !flush_req;
    assign rd_hit = wr_act && (ENABLE_BYPASS != 0) && (rd_index == wr_index);

    // Explicit wrap so non-power-of-2 way counts cycle correctly.
    assign victim_wr_cur = victim_mem[wr_index];
    assign victim_wr_nxt = (victim_wr_cur == VW'(NUM_WAYS - 1)) ? '0 : victim_wr_cur + VW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLEAR;
            clear_ptr <= '0;
        end else begin
            state     <= state_nxt;
            clear_ptr <= clear_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        clear_ptr_nxt = clear_ptr;
        case (state)
            CLEAR: begin
                clear_ptr_nxt = clear_ptr + PTR_W'(1);
                if (clear_ptr == PTR_W'(SETS - 1)) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (flush_req) begin
                    state_nxt     = CLEAR;
                    clear_ptr_nxt = '0;
                end
            end
            default: begin
                state_nxt     = CLEAR;
                clear_ptr_nxt = '0;
            end
        endcase
    end

    // Storage carries no reset; the sweep initialises every set.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                tag_mem[clear_idx][w] <= '0;
            end
            valid_mem[clear_idx]  <= '0;
            dirty_mem[clear_idx]  <= '0;
            victim_mem[clear_idx] <= '0;
        end else if (wr_act) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (wr_en[w]) begin
                    tag_mem[wr_index][w]   <= wr_tag;
                    valid_mem[wr_index][w] <= wr_valid;
                    dirty_mem[wr_index][w] <= wr_dirty;
                end
            end
            if (victim_adv) begin
                victim_mem[wr_index] <= victim_wr_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_tag    <= '0;
            rd_valid  <= '0;
            rd_dirty  <= '0;
            rd_victim <= '0;
        end else if (state == CLEAR) begin
            rd_tag    <= '0;
            rd_valid  <= '0;
            rd_dirty  <= '0;
            rd_victim <= '0;
        end else if (rd_en) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (rd_hit && wr_en[w]) begin
                    rd_tag[w*TAG_WIDTH +: TAG_WIDTH] <= wr_tag;
                    rd_valid[w]                      <= wr_valid;
                    rd_dirty[w]                      <= wr_dirty;
                end else begin
                    rd_tag[w*TAG_WIDTH +: TAG_WIDTH] <= tag_mem[rd_index][w];
                    rd_valid[w]                      <= valid_mem[rd_index][w];
                    rd_dirty[w]                      <= dirty_mem[rd_index][w];
                end
            end
            rd_victim <= (rd_hit && victim_adv) ? victim_wr_nxt : victim_mem[rd_index];
        end
    end

endmodule

// File: tb/tb_cache_tag_array.sv
// Directed bench: one 2-way bypassing instance and one 3-way non-bypassing instance share clock, reset and most stimulus.
module tb_cache_tag_array;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_req = 1'b0;
    logic        rd_en = 1'b0;
    logic [6:0]  rd_index = '0;
    logic [6:0]  wr_index = '0;
    logic [20:0] wr_tag = '0;
    logic        wr_valid = 1'b0;
    logic        wr_dirty = 1'b0;
    logic        victim_adv = 1'b0;
    logic [1:0]  wr_en_a = '0;
    logic [2:0]  wr_en_b = '0;

    logic        init_busy_a, init_busy_b;
    logic [41:0] rd_tag_a;
    logic [62:0] rd_tag_b;
    logic [1:0]  rd_valid_a, rd_dirty_a;
    logic [2:0]  rd_valid_b, rd_dirty_b;
    logic [0:0]  rd_victim_a;
    logic [1:0]  rd_victim_b;

    int compared = 0;
    int mismatched = 0;
    int n;

    always #5 clk = ~clk;

    cache_tag_array #(.NUM_WAYS(2), .INDEX_WIDTH(7), .TAG_WIDTH(21), .ENABLE_BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .flush_req(flush_req), .init_busy(init_busy_a),
        .rd_en(rd_en), .rd_index(rd_index), .rd_tag(rd_tag_a), .rd_valid(rd_valid_a),
        .rd_dirty(rd_dirty_a), .rd_victim(rd_victim_a), .wr_en(wr_en_a), .wr_index(wr_index),
        .wr_tag(wr_tag), .wr_valid(wr_valid), .wr_dirty(wr_dirty), .victim_adv(victim_adv)
    );

    cache_tag_array #(.NUM_WAYS(3), .INDEX_WIDTH(7), .TAG_WIDTH(21), .ENABLE_BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .flush_req(flush_req), .init_busy(init_busy_b),
        .rd_en(rd_en), .rd_index(rd_index), .rd_tag(rd_tag_b), .rd_valid(rd_valid_b),
        .rd_dirty(rd_dirty_b), .rd_victim(rd_victim_b), .wr_en(wr_en_b), .wr_index(wr_index),
        .wr_tag(wr_tag), .wr_valid(wr_valid), .wr_dirty(wr_dirty), .victim_adv(victim_adv)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_sweep();
        n = 0;
        while ((init_busy_a === 1'b1) && (n < 1000)) begin
            step();
            n++;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_valid_a", rd_valid_a, 0);
        chk("rst_tag_a", rd_tag_a, 0);
        chk("rst_busy_a", init_busy_a, 1);
        chk("rst_busy_b", init_busy_b, 1);

        // Initial sweep length
        rst = 1'b0;
        count_sweep();
        chk("init_sweep_len", n, 128);
        chk("init_busy_b_done", init_busy_b, 0);

        rd_en = 1'b1; rd_index = 7'd77;
        step();
        chk("post_init_valid", rd_valid_a, 0);
        chk("post_init_tag", rd_tag_a, 0);
        chk("post_init_victim", rd_victim_a, 0);
        chk("post_init_dirty", rd_dirty_a, 0);

        // Single-way write, then read back
        rd_en = 1'b0;
        wr_en_a = 2'b10; wr_en_b = 3'b010; wr_index = 7'd5;
        wr_tag = 21'h1ABCD; wr_valid = 1'b1; wr_dirty = 1'b1;
        step();
        wr_en_a = '0; wr_en_b = '0;
        rd_en = 1'b1; rd_index = 7'd5;
        step();
        chk("wr5_tag", rd_tag_a, {21'h1ABCD, 21'h0});
        chk("wr5_valid", rd_valid_a, 2'b10);
        chk("wr5_dirty", rd_dirty_a, 2'b10);

        // rd_en low holds the previous result
        rd_en = 1'b0; rd_index = 7'd9;
        step();
        chk("hold_valid", rd_valid_a, 2'b10);

        // Read/write collision on set 9
        wr_en_a = 2'b01; wr_en_b = 3'b001; wr_index = 7'd9;
        wr_tag = 21'h3; wr_valid = 1'b1; wr_dirty = 1'b0;
        rd_en = 1'b1; rd_index = 7'd9;
        step();
        chk("byp_tag_a", rd_tag_a, {21'h0, 21'h3});
        chk("byp_valid_a", rd_valid_a, 2'b01);
        chk("nobyp_tag_b", rd_tag_b, 0);
        chk("nobyp_valid_b", rd_valid_b, 3'b000);
        wr_en_a = '0; wr_en_b = '0;
        step();
        chk("after_valid_b", rd_valid_b, 3'b001);
        chk("after_tag_b", rd_tag_b[20:0], 21'h3);

        // Victim pointer: 2-way wraps 0,1,0 ; 3-way counts 0,1,2,0
        rd_en = 1'b0; victim_adv = 1'b1; wr_index = 7'd2;
        step();
        victim_adv = 1'b0; rd_en = 1'b1; rd_index = 7'd2;
        step();
        chk("vic1_a", rd_victim_a, 1);
        chk("vic1_b", rd_victim_b, 1);
        victim_adv = 1'b1;
        step();
        chk("vic_byp_a", rd_victim_a, 0);
        chk("vic_nobyp_b", rd_victim_b, 1);
        victim_adv = 1'b0;
        step();
        chk("vic2_a", rd_victim_a, 0);
        chk("vic2_b", rd_victim_b, 2);
        rd_en = 1'b0; victim_adv = 1'b1;
        step();
        victim_adv = 1'b0; rd_en = 1'b1;
        step();
        chk("vic3_a", rd_victim_a, 1);
        chk("vic3_b", rd_victim_b, 0);
        rd_index = 7'd3;
        step();
        chk("vic_idx3_b", rd_victim_b, 0);

        // Fill sets 0..3, then flush
        rd_en = 1'b0; wr_en_a = 2'b11; wr_en_b = 3'b111; wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_index = 7'(i); wr_tag = 21'(i + 1);
            step();
        end
        wr_en_a = '0; wr_en_b = '0;
        rd_en = 1'b1; rd_index = 7'd3;
        step();
        chk("fill3_valid", rd_valid_a, 2'b11);
        chk("fill3_tag", rd_tag_a, {21'h4, 21'h4});

        // Flush beats a colliding write: the read sees stored data, not the bypass
        flush_req = 1'b1; wr_en_a = 2'b11; wr_en_b = 3'b111; wr_index = 7'd3; wr_tag = 21'h55;
        step();
        chk("flush_over_wr", rd_tag_a, {21'h4, 21'h4});
        chk("flush_busy", init_busy_a, 1);
        flush_req = 1'b0; wr_index = 7'd1; rd_index = 7'd1;
        n = 0;
        while ((init_busy_a === 1'b1) && (n < 1000)) begin
            step();
            n++;
            flush_req = (n == 50);
            if (n == 60) chk("clear_rd_zero", rd_valid_a, 0);
        end
        chk("flush_sweep_len", n, 128);
        flush_req = 1'b0; wr_en_a = '0; wr_en_b = '0;
        for (int i = 0; i < 4; i++) begin
            rd_index = 7'(i);
            step();
            chk("flushed_valid_a", rd_valid_a, 0);
            chk("flushed_valid_b", rd_valid_b, 0);
        end

        // Async reset from idle, then reset mid-sweep
        wr_en_a = 2'b01; wr_en_b = 3'b001; wr_index = 7'd10; rd_en = 1'b0;
        step();
        wr_en_a = '0; wr_en_b = '0; rd_en = 1'b1; rd_index = 7'd10;
        step();
        chk("pre_rst_valid", rd_valid_a, 2'b01);
        rd_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", rd_valid_a, 0);
        chk("async_rst_busy", init_busy_a, 1);
        step();
        step();
        rst = 1'b0;
        repeat (40) step();
        chk("mid_sweep_busy", init_busy_a, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_sweep();
        chk("resweep_len", n, 128);
        rd_en = 1'b1; rd_index = 7'd10;
        step();
        chk("post_rst_valid", rd_valid_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
